i2s_tx_multich: RTL
===================

# i2s_tx_multich

Native multi-channel I2S transmitter that replaces the vendor I2S IP in the audio path. It accepts channel-tagged samples on an AXI4-Stream slave, assembles complete frames, buffers them in a frame FIFO and serialises them onto NUM_PAIRS stereo data lines sharing one SCLK/LRCLK pair. It adds selectable I2S or left-justified framing, configurable sample width and depth, sticky underflow and sequence-error status, and a single-clock design with no AXI-Lite register file.

## Interface
- DATA_W, 24, sample width in bits, 16..32; serialised MSB first in a fixed 32-bit slot.
- NUM_PAIRS, 1, stereo pairs (sdata lines), 1..4; channels 0..2*NUM_PAIRS-1.
- FIFO_DEPTH, 8, frame FIFO depth in complete frames, power of 2, ≥2.
- SCLK_DIV, 4, SCLK half-period in clock cycles, ≥2.
- s_axis_aud_aclk  in  1  sole clock.
- s_axis_aud_aresetn  in  1  reset, asynchronous assert, active-low.
- s_axis_aud_tdata  in  32  sample in [DATA_W-1:0]; upper bits ignored.
- s_axis_aud_tid  in  3  channel number; even = left, odd = right; pair = tid/2.
- s_axis_aud_tvalid  in  1  sample valid.
- s_axis_aud_tready  out  1  sample accepted when tvalid & tready.
- enable  in  1  serialiser run.
- lj_mode  in  1  0 = I2S (1-bit delay), 1 = left-justified; sample at frame boundaries only.
- clr_status  in  1  one-cycle pulse; clears sticky flags.
- lrclk_out  out  1  word select; 0 = left.
- sclk_out  out  1  bit clock.
- sdata_out  out  NUM_PAIRS  serial data, bit k carries channels 2k/2k+1.
- fifo_level  out  clog2(FIFO_DEPTH+1)  complete frames buffered.
- underflow  out  1  sticky: frame start with FIFO empty.
- seq_err  out  1  sticky: out-of-order tid.
- irq  out  1  underflow | seq_err.

## Operation
- Reset: all outputs 0; FIFO empty; assembler expects tid 0; sclk divider 0; bit counter bc = 63; status flags 0.
- Assembler: expected index exp (0..2N-1). Accepted sample with tid == exp is stored; exp increments; on tid == 2N-1 the full frame (2N samples) is pushed and exp returns to 0.
- tid != exp: if tid == 0, partial frame discarded, sample stored as channel 0, exp = 1; otherwise sample dropped. Either case sets seq_err. tid ≥ 2N: dropped, seq_err set.
- tready = !fifo_full (registered); a push never occurs while full.
- Serialiser, enable low: sclk_out = 0, sdata_out = 0, div = 0, bc = 63, lrclk_out = 0; FIFO keeps filling.
- Enable high: div counts 0..SCLK_DIV-1; at SCLK_DIV-1 sclk_out toggles. On each 1→0 toggle, bc advances mod 64 and sdata_out/lrclk_out update.
- On the falling edge where bc wraps 63→0: pop one frame into the shift registers and latch lj_mode; FIFO empty → load zeros, set underflow.
- Slot position p = bc mod 32; channel = bc/32 (0 = left). sdata_out[k] = sample[DATA_W-1-p] for p < DATA_W, else 0.
- lrclk_out = (bc ≥ 32) in LJ mode; ((bc+1) mod 64 ≥ 32) in I2S mode, i.e. it changes one SCLK before the MSB.
- enable deasserted mid-frame: immediate return to the idle state; the partial frame is lost, with no pop until the next frame start.
- Push and pop in the same cycle: level unchanged. clr_status coincident with a new error: the flag stays set.

## Timing
- SCLK period 2*SCLK_DIV clocks; frame = 64 SCLK = 128*SCLK_DIV clocks.
- First SCLK rise SCLK_DIV clocks after enable rises; first fall (frame start, MSB out) at 2*SCLK_DIV.
- Input to FIFO: fifo_level increments the cycle after the last sample of a frame is accepted.
- Frame available before a boundary: it is popped at that boundary. Data changes only on SCLK falling edges, so the receiver samples on the rising edge.
- Status flags set one cycle after the causing event; irq is combinational from the flags.

## Test plan
- NUM_PAIRS=1, DATA_W=24, I2S: push frame L=0xA5A5A5, R=0x5A5A5A, enable -> lrclk low for bc 63..30; sdata reproduces the MSB-first L bits on bc 0..23, zeros on 24..31; R on bc 32..55; no flags set.
- LJ mode, same data -> lrclk transitions exactly at bc 0 and 32, with the MSB coincident.
- Enable with empty FIFO -> sdata all 0 for the frame, underflow=1, irq=1; clr_status -> both 0.
- NUM_PAIRS=2: tid sequence 0,1,3 -> seq_err=1, sample 3 dropped; then 0,1,2,3 -> one frame pushed, fifo_level=1.
- Fill FIFO_DEPTH frames with enable low -> tready=0, level=FIFO_DEPTH; enable -> tready returns to 1 after the first pop.
- Assert reset mid-frame -> all outputs 0 immediately; FIFO empty after release.

Source files
------------

// File: rtl/i2s_tx_multich.sv
// Multi-channel I2S / left-justified transmitter.
// Contains an AXI4-Stream frame assembler, a frame FIFO and a serialiser that drives a shared SCLK/LRCLK pair.
module i2s_tx_multich #(
  parameter int unsigned DATA_W     = 24,
  parameter int unsigned NUM_PAIRS  = 1,
  parameter int unsigned FIFO_DEPTH = 8,
  parameter int unsigned SCLK_DIV   = 4
) (
  input  logic                               s_axis_aud_aclk,
  input  logic                               s_axis_aud_aresetn,
  input  logic [31:0]                        s_axis_aud_tdata,
  input  logic [2:0]                         s_axis_aud_tid,
  input  logic                               s_axis_aud_tvalid,
  output logic                               s_axis_aud_tready,
  input  logic                               enable,
  input  logic                               lj_mode,
  input  logic                               clr_status,
  output logic                               lrclk_out,
  output logic                               sclk_out,
  output logic [NUM_PAIRS-1:0]               sdata_out,
  output logic [$clog2(FIFO_DEPTH+1)-1:0]    fifo_level,
  output logic                               underflow,
  output logic                               seq_err,
  output logic                               irq
);
  localparam int unsigned NCH   = 2 * NUM_PAIRS;
  localparam int unsigned PTR_W = $clog2(FIFO_DEPTH);
  localparam int unsigned LVL_W = $clog2(FIFO_DEPTH + 1);
  localparam int unsigned DIV_W = $clog2(SCLK_DIV);

  typedef logic [NCH-1:0][DATA_W-1:0] frame_t;

  frame_t               mem [FIFO_DEPTH];
  frame_t               asm_q, asm_d, cur_q, cur_d;
  logic [2:0]           exp_q, exp_d;
  logic [PTR_W-1:0]     wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
  logic [LVL_W-1:0]     count_q, count_d;
  logic                 tready_q, tready_d;
  logic [DIV_W-1:0]     div_q, div_d;
  logic                 sclk_q, sclk_d;
  logic [5:0]           bc_q, bc_d, bc_p1;
  logic                 lj_q, lj_d, lrclk_q, lrclk_d;
  logic [NUM_PAIRS-1:0] sdata_q, sdata_d;
  logic                 underflow_q, underflow_d, seq_err_q, seq_err_d;
  logic                 accept, push, pop, uf_set, seq_set;
  logic [DATA_W-1:0]    smp;

  // Frame assembler: in-order channel capture, resync on channel 0
  always_comb begin
    exp_d   = exp_q;
    asm_d   = asm_q;
    push    = 1'b0;
    seq_set = 1'b0;
    accept  = s_axis_aud_tvalid & tready_q;
    if (accept) begin
      if (32'(s_axis_aud_tid) >= NCH) begin
        seq_set = 1'b1;
      end else if (s_axis_aud_tid == exp_q) begin
        for (int unsigned c = 0; c < NCH; c++) begin
          if (32'(s_axis_aud_tid) == c) asm_d[c] = s_axis_aud_tdata[DATA_W-1:0];
        end
        if (32'(s_axis_aud_tid) == NCH - 1) begin
          push  = 1'b1;
          exp_d = 3'd0;
        end else begin
          exp_d = exp_q + 3'd1;
        end
      end else begin
        seq_set = 1'b1;
        if (s_axis_aud_tid == 3'd0) begin
          asm_d[0] = s_axis_aud_tdata[DATA_W-1:0];
          exp_d    = 3'd1;
        end
      end
    end
  end

  // Serialiser: SCLK divider, bit counter, frame pop at bc wrap
  always_comb begin
    div_d   = div_q;
    sclk_d  = sclk_q;
    bc_d    = bc_q;
    bc_p1   = 6'd0;
    cur_d   = cur_q;
    lj_d    = lj_q;
    sdata_d = sdata_q;
    lrclk_d = lrclk_q;
    pop     = 1'b0;
    uf_set  = 1'b0;
    smp     = '0;
    if (!enable) begin
      div_d   = '0;
      sclk_d  = 1'b0;
      bc_d    = 6'd63;
      sdata_d = '0;
      lrclk_d = 1'b0;
    end else if (32'(div_q) == SCLK_DIV - 1) begin
      div_d  = '0;
      sclk_d = ~sclk_q;
      if (sclk_q) begin
        bc_d = bc_q + 6'd1;
        if (bc_d == 6'd0) begin
          lj_d = lj_mode;
          if (count_q == '0) begin
            cur_d  = '0;
            uf_set = 1'b1;
          end else begin
            cur_d = mem[rd_ptr_q];
            pop   = 1'b1;
          end
        end
        // Slot bits beyond DATA_W shift out to zero
        for (int unsigned k = 0; k < NUM_PAIRS; k++) begin
          smp        = bc_d[5] ? cur_d[2*k+1] : cur_d[2*k];
          smp        = smp << bc_d[4:0];
          sdata_d[k] = smp[DATA_W-1];
        end
        bc_p1   = bc_d + 6'd1;
        lrclk_d = lj_d ? bc_d[5] : bc_p1[5];
      end
    end else begin
      div_d = div_q + DIV_W'(1);
    end
  end

  // FIFO pointers, level, ready and sticky status
  always_comb begin
    wr_ptr_d = push ? wr_ptr_q + PTR_W'(1) : wr_ptr_q;
    rd_ptr_d = pop  ? rd_ptr_q + PTR_W'(1) : rd_ptr_q;
    count_d  = count_q;
    if (push && !pop)      count_d = count_q + LVL_W'(1);
    else if (pop && !push) count_d = count_q - LVL_W'(1);
    tready_d    = (count_d != LVL_W'(FIFO_DEPTH));
    underflow_d = (underflow_q & ~clr_status) | uf_set;
    seq_err_d   = (seq_err_q & ~clr_status) | seq_set;
  end

  always_ff @(posedge s_axis_aud_aclk or negedge s_axis_aud_aresetn) begin
    if (!s_axis_aud_aresetn) begin
      asm_q       <= '0;
      cur_q       <= '0;
      exp_q       <= 3'd0;
      wr_ptr_q    <= '0;
      rd_ptr_q    <= '0;
      count_q     <= '0;
      tready_q    <= 1'b0;
      div_q       <= '0;
      sclk_q      <= 1'b0;
      bc_q        <= 6'd63;
      lj_q        <= 1'b0;
      lrclk_q     <= 1'b0;
      sdata_q     <= '0;
      underflow_q <= 1'b0;
      seq_err_q   <= 1'b0;
    end else begin
      asm_q       <= asm_d;
      cur_q       <= cur_d;
      exp_q       <= exp_d;
      wr_ptr_q    <= wr_ptr_d;
      rd_ptr_q    <= rd_ptr_d;
      count_q     <= count_d;
      tready_q    <= tready_d;
      div_q       <= div_d;
      sclk_q      <= sclk_d;
      bc_q        <= bc_d;
      lj_q        <= lj_d;
      lrclk_q     <= lrclk_d;
      sdata_q     <= sdata_d;
      underflow_q <= underflow_d;
      seq_err_q   <= seq_err_d;
    end
  end

  always_ff @(posedge s_axis_aud_aclk) begin
    if (push) mem[wr_ptr_q] <= asm_d;
  end

  if (DATA_W < 32) begin : g_unused
    logic unused_tdata;
    assign unused_tdata = ^s_axis_aud_tdata[31:DATA_W];
  end

  assign s_axis_aud_tready = tready_q;
  assign lrclk_out         = lrclk_q;
  assign sclk_out          = sclk_q;
  assign sdata_out         = sdata_q;
  assign fifo_level        = count_q;
  assign underflow         = underflow_q;
  assign seq_err           = seq_err_q;
  assign irq               = underflow_q | seq_err_q;
endmodule
